// File: rtl/cb_pkg.sv
// Shared crossbar types: default word width, source index and the {src, data} word.
package cb_pkg;

  localparam int WIDTH = 8;

  typedef logic src_t;

  typedef struct packed {
    src_t             src;
    logic [WIDTH-1:0] data;
  } cb_word_t;

endpackage

// File: rtl/cb_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones, async active-high reset.
module cb_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cb_out_fifo.sv
// Receive FIFO behind one crossbar master port; val/rdy on both sides, no bypass paths.
// Per-source push counters are built only when CB_OUT_STATS_EN is defined.
module cb_out_fifo
  import cb_pkg::*;
#(
  parameter int WIDTH = cb_pkg::WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_val,
  input  logic                       in_src,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_rdy,
  output logic                       out_val,
  output logic                       out_src,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     count
`ifdef CB_OUT_STATS_EN
  ,
  output logic [CNT_W-1:0]           src0_cnt,
  output logic [CNT_W-1:0]           src1_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || WIDTH < 1) begin : g_bad_param
    $error("cb_out_fifo: DEPTH must be a power of two >= 2; WIDTH and CNT_W must be >= 1");
  end

  src_t             src_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             not_empty;

  assign not_empty = (count != '0);
  assign in_rdy    = !rst && (count != FULL);
  assign out_val   = not_empty;
  assign out_src   = not_empty ? src_mem[rd_ptr]  : 1'b0;
  assign out_data  = not_empty ? data_mem[rd_ptr] : '0;
  assign push      = in_val && in_rdy;
  assign pop       = out_val && out_rdy;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr]  <= in_src;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CB_OUT_STATS_EN
  cb_sat_cnt #(.CNT_W(CNT_W)) u_src0_cnt (
    .clk (clk),
    .rst (rst),
    .inc (push && (in_src == 1'b0)),
    .cnt (src0_cnt)
  );

  cb_sat_cnt #(.CNT_W(CNT_W)) u_src1_cnt (
    .clk (clk),
    .rst (rst),
    .inc (push && (in_src == 1'b1)),
    .cnt (src1_cnt)
  );
`endif

endmodule

// File: tb/tb_cb_out_fifo.sv
// Directed bench for cb_out_fifo (DEPTH=4, WIDTH=8); stats scenario runs when CB_OUT_STATS_EN is defined.
module tb_cb_out_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef CB_OUT_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_val;
  logic             in_src;
  logic [WIDTH-1:0] in_data;
  logic             in_rdy;
  logic             out_val;
  logic             out_src;
  logic [WIDTH-1:0] out_data;
  logic             out_rdy;
  logic [2:0]       count;
`ifdef CB_OUT_STATS_EN
  logic [CNT_W-1:0] src0_cnt;
  logic [CNT_W-1:0] src1_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cb_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_src   (in_src),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_val  (out_val),
    .out_src  (out_src),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .count    (count)
`ifdef CB_OUT_STATS_EN
    ,
    .src0_cnt (src0_cnt),
    .src1_cnt (src1_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; in_src = 1'b0; in_data = '0; out_rdy = 1'b0;
    step(); step();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b expected 0", out_val); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0", in_rdy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    rst = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_in_rdy: got %b expected 1", in_rdy); end
  endtask

  task automatic test_single();
    in_val = 1'b1; in_src = 1'b0; in_data = 8'h2B; out_rdy = 1'b1;
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL single_out_val: got %b expected 1", out_val); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL single_out_src: got %b expected 0", out_src); end
    checks++; if (out_data !== 8'h2B) begin errors++; $display("FAIL single_out_data: got %h expected 2b", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
    checks++; if (out_val !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL single_empty_out: got val %b data %h expected 0 00", out_val, out_data); end
  endtask

  task automatic test_full();
    logic [7:0] vals [4];
    vals[0] = 8'd34; vals[1] = 8'd21; vals[2] = 8'd7; vals[3] = 8'd9;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_src = 1'b0; in_data = vals[i];
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_in_rdy: got %b expected 0", in_rdy); end
    in_data = 8'd99; in_src = 1'b1;
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_no_accept: got %0d expected 4", count); end
    out_rdy = 1'b1;
    #1;
    checks++; if (out_data !== 8'd34 || in_rdy !== 1'b0) begin errors++; $display("FAIL full_head0: got data %0d rdy %b expected 34 0", out_data, in_rdy); end
    step();
    checks++; if (count !== 3'd3 || in_rdy !== 1'b1 || out_data !== 8'd21) begin errors++; $display("FAIL full_pop1: got count %0d rdy %b data %0d expected 3 1 21", count, in_rdy, out_data); end
    step();
    in_val = 1'b0;
    checks++; if (count !== 3'd3 || out_data !== 8'd7) begin errors++; $display("FAIL full_pop2: got count %0d data %0d expected 3 7", count, out_data); end
    step();
    checks++; if (count !== 3'd2 || out_data !== 8'd9) begin errors++; $display("FAIL full_pop3: got count %0d data %0d expected 2 9", count, out_data); end
    step();
    checks++; if (count !== 3'd1 || out_data !== 8'd99 || out_src !== 1'b1) begin errors++; $display("FAIL full_pop4: got count %0d data %0d src %b expected 1 99 1", count, out_data, out_src); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    out_rdy = 1'b0; in_val = 1'b1; in_src = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = 8'h50 + 8'(i); q.push_back(in_data);
      step();
    end
    out_rdy = 1'b1;
    for (int i = 2; i < 12; i++) begin
      in_data = 8'h50 + 8'(i);
      #1;
      checks++; if (count !== 3'd2 || out_data !== q[0]) begin errors++; $display("FAIL b2b_cycle%0d: got count %0d data %h expected 2 %h", i, count, out_data, q[0]); end
      q.push_back(in_data);
      void'(q.pop_front());
      step();
    end
    in_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_data !== q[0]) begin errors++; $display("FAIL b2b_drain%0d: got %h expected %h", i, out_data, q[0]); end
      void'(q.pop_front());
      step();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", count); end
  endtask

  task automatic test_async_reset();
    out_rdy = 1'b0; in_val = 1'b1; in_src = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
    in_val = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL arst_pre_count: got %0d expected 3", count); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_val !== 1'b0 || in_rdy !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL arst_immediate: got val %b rdy %b count %0d expected 0 0 0", out_val, in_rdy, count); end
    step(); step();
    rst = 1'b0;
    in_val = 1'b1; in_data = 8'h12;
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1 || out_data !== 8'h12 || count !== 3'd1) begin errors++; $display("FAIL arst_first_out: got val %b data %h count %0d expected 1 12 1", out_val, out_data, count); end
    out_rdy = 1'b1;
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_drain: got %0d expected 0", count); end
  endtask

  task automatic test_src_alternate();
    logic       exp_src;
    logic [7:0] exp_data;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_src = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_data = 8'hC0 + 8'(i);
      in_val = 1'b1; in_src = exp_src; in_data = exp_data;
      step();
      checks++; if (out_val !== 1'b1 || out_src !== exp_src || out_data !== exp_data || count !== 3'd1) begin errors++; $display("FAIL alt_word%0d: got val %b src %b data %h count %0d expected 1 %b %h 1", i, out_val, out_src, out_data, count, exp_src, exp_data); end
    end
    in_val = 1'b0;
    step();
    checks++; if (count !== 3'd0 || out_val !== 1'b0) begin errors++; $display("FAIL alt_empty: got count %0d val %b expected 0 0", count, out_val); end
  endtask

`ifdef CB_OUT_STATS_EN
  task automatic test_stats();
    rst = 1'b1; in_val = 1'b0;
    step();
    checks++; if (src0_cnt !== 2'd0 || src1_cnt !== 2'd0) begin errors++; $display("FAIL stats_reset: got %0d %0d expected 0 0", src0_cnt, src1_cnt); end
    rst = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1; in_src = 1'b1; in_data = 8'(i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      in_val = 1'b1; in_src = 1'b0; in_data = 8'(i);
      step();
    end
    in_val = 1'b0;
    step();
    checks++; if (src1_cnt !== 2'd3) begin errors++; $display("FAIL stats_src1_sat: got %0d expected 3", src1_cnt); end
    checks++; if (src0_cnt !== 2'd2) begin errors++; $display("FAIL stats_src0: got %0d expected 2", src0_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_async_reset();
    test_src_alternate();
`ifdef CB_OUT_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cb_out_fifo.md
Name: cb_out_fifo

Overview:
- Receive buffer placed directly downstream of one crossbar master port (`m0_*` or `m1_*`). Instantiated once per master port.
- Accepts `{src, data}` words from the crossbar over a val/rdy handshake and queues them in a small circular FIFO.
- Presents the queued words to the consumer over a val/rdy handshake.
- Decouples consumer stalls from crossbar arbitration, so a slow consumer does not back-pressure the crossbar on every cycle.

Parameters:
- `WIDTH`, 8, data word width; must match the crossbar's `WIDTH`.
- `DEPTH`, 4, FIFO entries; a power of two and at least 2.
- `CNT_W`, 16, width of each per-source statistics counter; used only with `CB_OUT_STATS_EN`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_val` input 1: crossbar master valid (`mN_val`).
- `in_src` input 1: source port index of the word (`mN_src`).
- `in_data` input `WIDTH`: word payload (`mN_data`).
- `in_rdy` output 1: buffer can accept a word (drives `mN_rdy`).
- `out_val` output 1: head word is valid.
- `out_src` output 1: source index of the head word.
- `out_data` output `WIDTH`: payload of the head word.
- `out_rdy` input 1: consumer accepts the head word.
- `count` output `$clog2(DEPTH)+1`: current occupancy.
- `src0_cnt` output `CNT_W`: words accepted from source 0 (`CB_OUT_STATS_EN` only).
- `src1_cnt` output `CNT_W`: words accepted from source 1 (`CB_OUT_STATS_EN` only).

Behaviour:
- Handshakes:
  - Push occurs when `in_val && in_rdy` at a `clk` rising edge.
  - Pop occurs when `out_val && out_rdy` at a `clk` rising edge.
  - `in_val`/`in_src`/`in_data` may change freely while `in_rdy`=0.
  - Once the buffer asserts `out_val`, it holds `out_val`/`out_src`/`out_data` stable until the pop.
- Combinational outputs:
  - `in_rdy` = !rst && (`count` != `DEPTH`).
  - `out_val` = (`count` != 0).
  - `out_src`/`out_data` = storage at `rd_ptr` when `count` != 0; otherwise forced to 0.
- State registers: `wr_ptr` and `rd_ptr` (`$clog2(DEPTH)` bits each) and `count`.
  - Pointers wrap naturally from `DEPTH`-1 to 0 because `DEPTH` is a power of two.
- Update rule, by event:
  - Push only: write `{in_src, in_data}` at `wr_ptr`; `wr_ptr`+1; `count`+1.
  - Pop only: `rd_ptr`+1; `count`-1.
  - Push and pop together: both pointers advance; `count` unchanged. Legal at any occupancy from 1 to `DEPTH`-1.
- Full (`count`=`DEPTH`): `in_rdy`=0, so no push happens that cycle, even if a pop also occurs. There is no full-bypass; `in_rdy` rises the cycle after the pop.
- Empty (`count`=0): no pop; no bypass. A word pushed at edge N appears on `out_val` after edge N. Minimum in-to-out latency is 1 cycle.
- Throughput: 1 word/cycle sustained whenever 0 < `count` < `DEPTH` and both sides are active.
- Reset (asynchronous, at any time including mid-transfer):
  - `wr_ptr`=`rd_ptr`=`count`=0.
  - `out_val`=0, `out_src`=0, `out_data`=0, `in_rdy`=0 while `rst` is high.
  - Stats counters (when enabled) = 0.
  - In-flight words are discarded; storage array contents are not reset.
- Ordering: strict FIFO order regardless of `in_src`. No reordering or dropping except at reset.

Optional Feature:
- Macro: `CB_OUT_STATS_EN`.
- Defined:
  - `src0_cnt`/`src1_cnt` ports exist.
  - On every push, the counter selected by `in_src` increments by 1.
  - Counters saturate at all-ones (no wrap).
  - Both counters are cleared by `rst`.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `cb_pkg`:
  - `WIDTH` default constant (8).
  - `src_t` typedef (1-bit port index).
  - `cb_word_t` packed struct `{src_t src; logic [WIDTH-1:0] data}`, reused by the crossbar and by this buffer.
- One natural sub-module: `cb_sat_cnt`, a saturating `CNT_W` counter with increment enable and async reset. Instantiated twice under `CB_OUT_STATS_EN`.
- The FIFO core stays inline.

Test Plan:
1. Reset, then push (src 0, 8'h2B) with `out_rdy`=1 → `out_val`=1 the next cycle with `out_src`=0, `out_data`=8'h2B. Popped at that edge, so `count` returns to 0.
2. Hold `out_rdy`=0 and push 34, 21, 7, 9 (`DEPTH`=4) → `count`=4 and `in_rdy`=0. A 5th word held on `in_val` is not accepted. Raise `out_rdy` → pops 34, 21, 7, 9 in order; `in_rdy`=1 one cycle after the first pop.
3. Continuous push and pop at `count`=2 for 10 cycles → `count` stays 2, data exits in order, pointers wrap past 3 without loss.
4. Assert `rst` asynchronously (between edges) with `count`=3 → `out_val`, `in_rdy`, and `count` go to 0 immediately. After release, push 8'h12 → the first output is 8'h12.
5. Empty FIFO with `out_rdy`=1: push on consecutive cycles alternating src 1 and src 0 → every output carries the matching `out_src`, with 1-cycle latency.
6. With `CB_OUT_STATS_EN`, `CNT_W`=2: push 5 words from src 1 and 2 from src 0 → `src1_cnt`=3 (saturated), `src0_cnt`=2.
